down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
Programmable down-counting timer. It is the counting-down counterpart of the team's free-running up counters and sits beside them in the counters library. It loads a reload value, counts down on qualified ticks, and flags terminal count. It runs in one-shot or periodic mode, with start/stop control and status outputs, for use as a prescaler or watchdog-style interval timer.

Parameters:
WIDTH, 4, counter and reload register width in bits (legal range 2..32)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
load  in  1  capture load_val into reload register and counter
load_val  in  WIDTH  reload value (unsigned)
start  in  1  begin or restart a count from the reload value
stop  in  1  halt counting, counter holds
periodic  in  1  1 = auto-reload at terminal count; 0 = one-shot; sampled at each terminal count
ce  in  1  count enable (tick qualifier); counting advances only when ce=1
Q  out  WIDTH  current count value (registered)
tc  out  1  terminal-count pulse, exactly one clk cycle wide (registered)
busy  out  1  1 while in RUN
done  out  1  1 while in EXPIRED (one-shot finished)

Behaviour:
- State machine with 3 states: IDLE, RUN, EXPIRED. All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- Reset (rst=1 at edge): state=IDLE, Q=0, reload reg=0, tc=0, busy=0, done=0. Reset has priority over every other input, including mid-count.
- Per-edge priority, highest first: rst > load > stop > start > count.
- load (any state): reload<=load_val, Q<=load_val, state->IDLE, tc=0. Simultaneous start and stop are ignored that cycle.
- stop:
  - In RUN: state->IDLE, Q holds its value, tc=0.
  - In IDLE or EXPIRED: no effect.
- start:
  - In any state, when reload!=0: Q<=reload, state->RUN, tc=0. A start while in RUN restarts the count.
  - When reload==0: start is ignored and the state is unchanged.
- In RUN with ce=0: Q holds and tc=0.
- In RUN with ce=1 and Q>1: Q<=Q-1 and tc=0.
- In RUN with ce=1 and Q==1 (terminal count): tc<=1 for one cycle.
  - periodic=1: Q<=reload, stay in RUN.
  - periodic=0: Q<=0, state->EXPIRED.
- In RUN, a value Q==0 (reachable only via load of 0 followed by start, which is already blocked) is treated as terminal count. This is defensive only.
- Period: with ce held at 1, tc fires every reload cycles in periodic mode. First tc is reload cycles after the edge that sampled start.
- Latency: tc and the new Q/state appear on the same edge, one cycle after ce is sampled with Q==1.
- EXPIRED: Q=0 and done=1 until start or load. ce is ignored.
- Arithmetic: unsigned WIDTH-bit decrement. No underflow wrap can occur, because the Q==1 check precedes it. The maximum reload of 2^WIDTH-1 must work.
- busy = (state==RUN); done = (state==EXPIRED).

Decomposition:
- Package down_timer_pkg: state encoding constants (IDLE=2'b00, RUN=2'b01, EXPIRED=2'b10), with 2'b11 illegal and recovering to IDLE on the next edge.
- Single module; no sub-module needed. The reload register and the counter stay in the same always block as the FSM.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN (WIDTH=4, reload=9, Q=5) -> next edge Q=0, tc=0, busy=0, done=0, state IDLE.
- One-shot: load 4, start, ce=1 continuous -> Q sequence 4,3,2,1,0. tc high only on the cycle Q becomes 0. done=1, busy=0 afterwards; further ce changes nothing.
- Periodic with gated ce: load 3, periodic=1, start, ce toggling 1,0,1,0... -> Q steps only on ce=1: 3,2,1,3. tc pulses once per 3 ce ticks, never 2 cycles wide.
- Stop/restart/priority: while counting from 15 at Q=10, assert stop -> Q holds 10, busy=0. Then start -> Q=15. Same-cycle load=7 with start=1 -> Q=7, state IDLE.
- Boundaries: load 0 then start -> remains IDLE, Q=0, tc never asserts. load 15 (max), periodic, ce=1 -> tc every 15 cycles over 3 periods, and Q never shows 0.
- Restart in RUN: reload 5, at Q=2 assert start -> Q=5, no tc emitted for the aborted count.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types for the down-counting interval timer.
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_e;

endpackage

// File: rtl/down_timer.sv
// Programmable down-counting timer: one-shot or periodic,
// with a one-cycle terminal-count pulse.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             ce,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             at_tc;

  // Q==0 in RUN is counted as terminal so the decrement can never wrap.
  assign at_tc = (q_q == WIDTH'(1)) || (q_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      reload_d = load_val;
      q_d      = load_val;
      state_d  = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (start && (reload_q != '0)) begin
      q_d     = reload_q;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (ce) begin
            if (at_tc) begin
              tc_d = 1'b1;
              if (periodic) begin
                q_d = reload_q;
              end else begin
                q_d     = '0;
                state_d = EXPIRED;
              end
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
        end
        EXPIRED: q_d = '0;
        default: state_d = IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == EXPIRED);

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer (WIDTH=4).
module tb_down_timer;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst, load, start, stop, periodic, ce;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tc, busy, done;

  int n_run  = 0;
  int n_fail = 0;

  down_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .periodic(periodic), .ce(ce),
    .Q(Q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int q, input int t, input int b, input int d);
    chk({tag, ".Q"},    32'(Q),    32'(q));
    chk({tag, ".tc"},   32'(tc),   32'(t));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = WIDTH'(v);
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int tc_cnt;
  int exp_q1 [5] = '{3, 2, 1, 0, 0};
  int exp_t1 [5] = '{0, 0, 0, 1, 0};
  int exp_q2 [7] = '{2, 2, 1, 1, 3, 3, 2};
  int exp_t2 [7] = '{0, 0, 0, 0, 1, 0, 0};

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0;
    stop = 1'b0; periodic = 1'b0; ce = 1'b0;
    #1;
    step(); step();
    chk_all("reset_init", 0, 0, 0, 0);
    rst = 1'b0;

    // Reset mid-count
    do_load(9);
    do_start();
    chk_all("rst_run_start", 9, 0, 1, 0);
    ce = 1'b1;
    repeat (4) step();
    chk_all("rst_run_q5", 5, 0, 1, 0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_all("rst_mid", 0, 0, 0, 0);
    do_start();  // reload was cleared, so start is ignored
    chk_all("rst_reload_cleared", 0, 0, 0, 0);

    // One-shot
    do_load(4);
    do_start();
    chk_all("os_start", 4, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("os_%0d", i), exp_q1[i], exp_t1[i], exp_q1[i] != 0 ? 1 : 0,
              (i >= 3) ? 1 : 0);
    end
    ce = 1'b0; step(); ce = 1'b1; step();
    chk_all("os_expired_hold", 0, 0, 0, 1);

    // Periodic with gated ce
    do_load(3);
    periodic = 1'b1;
    do_start();
    chk_all("per_start", 3, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      ce = ((i % 2) == 0);
      step();
      chk_all($sformatf("per_%0d", i), exp_q2[i], exp_t2[i], 1, 0);
    end

    // Stop / restart / load priority
    periodic = 1'b0; ce = 1'b1;
    do_load(15);
    do_start();
    repeat (5) step();
    chk_all("stop_pre", 10, 0, 1, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk_all("stop_hold", 10, 0, 0, 0);
    step();
    chk_all("stop_idle_hold", 10, 0, 0, 0);
    do_start();
    chk_all("stop_restart", 15, 0, 1, 0);
    load = 1'b1; load_val = 4'd7; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    chk_all("load_over_start", 7, 0, 0, 0);

    // Reload of zero blocks start
    do_load(0);
    do_start();
    chk_all("zero_start", 0, 0, 0, 0);
    tc_cnt = 0;
    repeat (3) begin step(); tc_cnt += int'(tc); end
    chk("zero_no_tc", 32'(tc_cnt), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);

    // Max reload, periodic, three periods
    periodic = 1'b1; ce = 1'b1;
    do_load(15);
    do_start();
    tc_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      step();
      chk($sformatf("max_q_%0d", k), 32'(Q), (k % 15 == 0) ? 32'd15 : 32'(15 - (k % 15)));
      chk($sformatf("max_tc_%0d", k), 32'(tc), (k % 15 == 0) ? 32'd1 : 32'd0);
      tc_cnt += int'(tc);
    end
    chk("max_tc_count", 32'(tc_cnt), 32'd3);

    // Restart while running
    periodic = 1'b0;
    do_load(5);
    do_start();
    repeat (3) step();
    chk_all("rr_pre", 2, 0, 1, 0);
    do_start();
    chk_all("rr_restart", 5, 0, 1, 0);
    step();
    chk_all("rr_after", 4, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
